// File: rtl/red_pitaya_pwm_pkg.sv
// Shared constants, counter widths and decoder state encoding for the PWM
// generator/receiver pair.
package red_pitaya_pwm_pkg;

  localparam int PWM_FULL_DEF = 156;
  localparam int FRM_LEN      = 16;
  localparam int N_CH         = 4;
  localparam int CNT_W        = 8;
  localparam int SUM_W        = 12;
  localparam int FCNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_LOCK  = 2'd2
  } pwm_rx_state_t;

endpackage

// File: rtl/red_pitaya_pwm_rx_ch.sv
// Single PWM channel: per-period high-cycle counter and 16-period frame sum.
module red_pitaya_pwm_rx_ch
  import red_pitaya_pwm_pkg::*;
(
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr,
  input  logic             en,
  input  logic             per_end,
  input  logic             frm_end,
  input  logic             pwm,
  output logic [CNT_W-1:0] per_cnt,
  output logic [SUM_W-1:0] frm_sum
);

  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] hi_next;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] acc_next;

  // Period-end sample is folded into both the period count and the frame sum.
  assign hi_next  = hi_cnt + {{(CNT_W-1){1'b0}}, pwm};
  assign acc_next = acc + {{(SUM_W-CNT_W){1'b0}}, hi_next};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hi_cnt  <= '0;
      acc     <= '0;
      per_cnt <= '0;
      frm_sum <= '0;
    end else if (clr) begin
      hi_cnt <= '0;
      acc    <= '0;
    end else if (en) begin
      if (per_end) begin
        hi_cnt  <= '0;
        per_cnt <= hi_next;
        if (frm_end) begin
          acc     <= '0;
          frm_sum <= acc_next;
        end else begin
          acc <= acc_next;
        end
      end else begin
        hi_cnt <= hi_next;
      end
    end
  end

endmodule

// File: rtl/red_pitaya_pwm_rx.sv
// Four-channel PWM decoder. States: IDLE waits for sync, ALIGN counts down the
// sync-to-frame delay, LOCK tracks period/frame position and emits results.
module red_pitaya_pwm_rx
  import red_pitaya_pwm_pkg::*;
#(
  parameter int PWM_FULL = PWM_FULL_DEF,
  parameter int SYNC_DLY = 3
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    ena_i,
  input  logic [N_CH-1:0]         pwm_i,
  input  logic                    sync_i,
  output logic [N_CH*CNT_W-1:0]   per_cnt_o,
  output logic                    per_vld_o,
  output logic [N_CH*SUM_W-1:0]   frm_sum_o,
  output logic                    frm_vld_o,
  output logic                    locked_o,
  output logic                    sync_err_o
);

  localparam int PCNT_W = $clog2(PWM_FULL + 1);
  localparam logic [PCNT_W-1:0] P_FULL     = PCNT_W'(PWM_FULL);
  localparam logic [PCNT_W-1:0] P_SYNC_POS = PCNT_W'(PWM_FULL - SYNC_DLY);
  localparam logic [PCNT_W-1:0] P_DLY_LD   = PCNT_W'((SYNC_DLY > 0) ? SYNC_DLY - 1 : 0);
  localparam bit                ZERO_DLY   = (SYNC_DLY == 0);

  pwm_rx_state_t     state, state_nxt;
  logic [PCNT_W-1:0] dly, dly_nxt;
  logic [PCNT_W-1:0] pcnt, pcnt_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic              sync_ok, sync_bad, per_end, frm_end, run, ch_clr;

  assign sync_ok  = (fcnt == FCNT_W'(FRM_LEN - 1)) && (pcnt == P_SYNC_POS);
  assign sync_bad = (state == ST_LOCK) && ena_i && sync_i && !sync_ok;
  assign per_end  = (pcnt == P_FULL);
  assign frm_end  = per_end && (fcnt == FCNT_W'(FRM_LEN - 1));
  assign run      = (state == ST_LOCK) && ena_i && !sync_bad;
  assign ch_clr   = (state != ST_LOCK) || !ena_i || sync_bad;
  assign locked_o = (state == ST_LOCK);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ST_IDLE;
      dly        <= '0;
      pcnt       <= '0;
      fcnt       <= '0;
      per_vld_o  <= 1'b0;
      frm_vld_o  <= 1'b0;
      sync_err_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      dly        <= dly_nxt;
      pcnt       <= pcnt_nxt;
      fcnt       <= fcnt_nxt;
      per_vld_o  <= run && per_end;
      frm_vld_o  <= run && frm_end;
      sync_err_o <= sync_bad;
    end
  end

  always_comb begin
    state_nxt = state;
    dly_nxt   = dly;
    pcnt_nxt  = pcnt;
    fcnt_nxt  = fcnt;
    if (!ena_i) begin
      state_nxt = ST_IDLE;
      dly_nxt   = '0;
      pcnt_nxt  = '0;
      fcnt_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE, ST_ALIGN: begin
          if (sync_i) begin
            // With zero delay the cycle after sync is already position 1.
            state_nxt = ZERO_DLY ? ST_LOCK : ST_ALIGN;
            dly_nxt   = P_DLY_LD;
            pcnt_nxt  = ZERO_DLY ? PCNT_W'(1) : '0;
            fcnt_nxt  = '0;
          end else if (state == ST_ALIGN) begin
            if (dly == '0) begin
              state_nxt = ST_LOCK;
              pcnt_nxt  = PCNT_W'(1);
              fcnt_nxt  = '0;
            end else begin
              dly_nxt = dly - PCNT_W'(1);
            end
          end
        end
        ST_LOCK: begin
          if (sync_bad) begin
            state_nxt = ZERO_DLY ? ST_LOCK : ST_ALIGN;
            dly_nxt   = P_DLY_LD;
            pcnt_nxt  = ZERO_DLY ? PCNT_W'(1) : '0;
            fcnt_nxt  = '0;
          end else if (per_end) begin
            pcnt_nxt = PCNT_W'(1);
            fcnt_nxt = fcnt + FCNT_W'(1);
          end else begin
            pcnt_nxt = pcnt + PCNT_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  for (genvar n = 0; n < N_CH; n++) begin : g_ch
    red_pitaya_pwm_rx_ch u_ch (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .clr     (ch_clr),
      .en      (run),
      .per_end (per_end),
      .frm_end (frm_end),
      .pwm     (pwm_i[n]),
      .per_cnt (per_cnt_o[n*CNT_W +: CNT_W]),
      .frm_sum (frm_sum_o[n*SUM_W +: SUM_W])
    );
  end

endmodule

// File: tb/tb_red_pitaya_pwm_rx.sv
// Bench for red_pitaya_pwm_rx: encoder-driven stimulus, cycle model from the
// sync/anchor timing rules, and literal checks on captured results.
module tb_red_pitaya_pwm_rx;

  localparam int FULL  = 156;
  localparam int D     = 3;
  localparam int FRM   = 16 * FULL;
  localparam int NSYNC = FRM - D - 1;

  logic        clk = 1'b0, rstn = 1'b0, ena = 1'b0, sync = 1'b0;
  logic [3:0]  pwm = '0;
  logic [31:0] per_cnt;
  logic [47:0] frm_sum;
  logic        per_vld, frm_vld, locked, sync_err;

  always #5 clk = ~clk;

  red_pitaya_pwm_rx #(.PWM_FULL(FULL), .SYNC_DLY(D)) dut (
    .clk_i(clk), .rstn_i(rstn), .ena_i(ena), .pwm_i(pwm), .sync_i(sync),
    .per_cnt_o(per_cnt), .per_vld_o(per_vld), .frm_sum_o(frm_sum),
    .frm_vld_o(frm_vld), .locked_o(locked), .sync_err_o(sync_err)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: anchor = cycle index of position 1 of frame period 0.
  logic [3:0]  hist [0:65535];
  int          cyc = 0;
  bit          armed = 0;
  int          anchor = 0;
  logic [31:0] e_per = '0;
  logic [47:0] e_frm = '0;
  logic        e_pv = 0, e_fv = 0, e_lk = 0, e_err = 0;

  function automatic int win_sum(input int c, input int len, input int ch);
    int s = 0;
    for (int i = c - len + 1; i <= c; i++) s += int'(hist[i][ch]);
    return s;
  endfunction

  always @(posedge clk) begin : model_p
    int c;
    c = cyc;
    hist[c] = pwm;
    e_pv = 0; e_fv = 0; e_err = 0;
    if (!rstn) begin
      armed = 0; e_per = '0; e_frm = '0; e_lk = 0;
    end else if (!ena) begin
      armed = 0; e_lk = 0;
    end else begin
      if (armed && c >= anchor) begin
        if (sync && ((c + 1 + D - anchor) % FRM) != 0) begin
          e_err = 1;
          anchor = c + 1 + D;
        end else if ((c - anchor) % FULL == FULL - 1) begin
          e_pv = 1;
          for (int ch = 0; ch < 4; ch++) e_per[8*ch +: 8] = 8'(win_sum(c, FULL, ch));
          if (((c - anchor) / FULL) % 16 == 15) begin
            e_fv = 1;
            for (int ch = 0; ch < 4; ch++) e_frm[12*ch +: 12] = 12'(win_sum(c, FRM, ch));
          end
        end
      end else if (sync) begin
        armed = 1;
        anchor = c + 1 + D;
      end
      e_lk = armed && (c + 1 >= anchor);
    end
    cyc++;
  end

  logic [31:0] per_q[$];
  logic [47:0] frm_q[$];
  int   err_cnt = 0, err_cyc = -1, lk_rise = -1, frm_after_err = -1;
  logic err_locked = 1'b1, prev_lk = 1'b0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("locked",   locked,   e_lk);
      check("per_vld",  per_vld,  e_pv);
      check("per_cnt",  per_cnt,  e_per);
      check("frm_vld",  frm_vld,  e_fv);
      check("frm_sum",  frm_sum,  e_frm);
      check("sync_err", sync_err, e_err);
      if (per_vld) per_q.push_back(per_cnt);
      if (frm_vld) begin
        frm_q.push_back(frm_sum);
        if (err_cnt > 0 && frm_after_err < 0) frm_after_err = cyc;
      end
      if (sync_err) begin
        err_cnt++; err_cyc = cyc; err_locked = locked;
      end
      if (locked && !prev_lk && err_cnt > 0 && lk_rise < 0) lk_rise = cyc;
      prev_lk = locked;
    end
  end

  task automatic tick(input logic s, input logic [3:0] p);
    @(negedge clk); #1;
    sync = s; pwm = p;
  endtask

  task automatic gap();
    repeat (D) tick(1'b0, 4'h0);
  endtask

  // Encoder: period k high for (v[23:16] + v[k]) cycles from position 1.
  task automatic run(input logic [3:0][23:0] v, input int ncyc, input int sync_at);
    for (int i = 0; i < ncyc; i++) begin
      int j, k, pos;
      logic [3:0] p;
      logic s;
      j = i % FRM; k = j / FULL; pos = j % FULL + 1;
      for (int ch = 0; ch < 4; ch++)
        p[ch] = (pos <= int'(v[ch][23:16]) + int'(v[ch][k]));
      s = (sync_at < FRM) ? (j == sync_at) : (i == sync_at);
      tick(s, p);
    end
  endtask

  localparam logic [3:0][23:0] V50  = {4{24'h500000}};
  localparam logic [3:0][23:0] VB   = {24'h500000, 24'h500000, 24'h3200FF, 24'h500000};
  localparam logic [3:0][23:0] V1   = {4{24'hFF0000}};
  localparam logic [3:0][23:0] V0   = {4{24'h000000}};
  localparam logic [3:0][23:0] V32  = {4{24'h320000}};
  localparam logic [3:0][23:0] V10  = {4{24'h10000F}};

  initial begin
    int n0;
    repeat (3) tick(1'b0, 4'h0);
    check("rst_per_cnt", per_cnt, 32'h0);
    check("rst_frm_sum", frm_sum, 48'h0);
    check("rst_locked", locked, 1'b0);
    @(negedge clk); #1; rstn = 1'b1; ena = 1'b1;
    repeat (10) tick(1'b0, 4'hF);
    check("idle_unlocked", locked, 1'b0);

    tick(1'b1, 4'h0); gap();
    run(V50, 2 * FRM, NSYNC);
    run(VB, FRM, NSYNC);
    run(V1, FRM, NSYNC);
    run(V0, FRM, NSYNC);
    run(V50, FRM + 2, FRM + 1);   // sync arrives 5 clk late
    gap();
    run(V50, FRM, NSYNC);
    run(V50, 1000, NSYNC);

    check("frm_q_len", 64'(frm_q.size()), 64'd7);
    check("per_q_len_ok", 64'(per_q.size() >= 96), 64'd1);
    check("frm0_50", frm_q[0], 48'h500500500500);
    check("frm1_50", frm_q[1], 48'h500500500500);
    check("frm2_chb", frm_q[2], 48'h500500328500);
    check("frm3_ones", frm_q[3], 48'h9C09C09C09C0);
    check("frm4_zero", frm_q[4], 48'h0);
    check("frm5_pre_err", frm_q[5], 48'h500500500500);
    check("frm6_relock", frm_q[6], 48'h500500500500);
    check("per0_50", per_q[0], 32'h50505050);
    check("per31_50", per_q[31], 32'h50505050);
    check("per32_chb", per_q[32], 32'h50503350);
    check("per39_chb", per_q[39], 32'h50503350);
    check("per40_chb", per_q[40], 32'h50503250);
    check("per48_ones", per_q[48], 32'h9C9C9C9C);
    check("per64_zero", per_q[64], 32'h0);
    check("err_count", 64'(err_cnt), 64'd1);
    check("err_unlocked", err_locked, 1'b0);
    check("relock_dly", 64'(lk_rise - err_cyc), 64'(D));
    check("frm_after_err", 64'(frm_after_err - err_cyc), 64'(D + FRM));

    @(negedge clk); #1; ena = 1'b0;
    @(negedge clk); #1;
    check("ena_unlocked", locked, 1'b0);
    check("ena_hold_per", per_cnt, 32'h50505050);
    check("ena_hold_frm", frm_sum, 48'h500500500500);
    ena = 1'b1;
    n0 = per_q.size();
    repeat (200) tick(1'b0, 4'hF);
    check("ena_no_strobe", 64'(per_q.size() - n0), 64'd0);
    tick(1'b1, 4'h0); gap();
    run(V32, FRM, NSYNC);
    repeat (2) tick(1'b0, 4'h0);
    check("frm_v32", frm_q[frm_q.size()-1], 48'h320320320320);

    run(V50, 700, NSYNC);
    @(negedge clk); #1; rstn = 1'b0; #1;
    check("arst_per", per_cnt, 32'h0);
    check("arst_frm", frm_sum, 48'h0);
    check("arst_locked", locked, 1'b0);
    repeat (2) tick(1'b0, 4'h0);
    @(negedge clk); #1; rstn = 1'b1;
    n0 = frm_q.size();
    repeat (20) tick(1'b0, 4'hF);
    tick(1'b1, 4'h0); gap();
    run(V10, FRM, NSYNC);
    repeat (2) tick(1'b0, 4'h0);
    check("rst_frm_count", 64'(frm_q.size() - n0), 64'd1);
    check("frm_v10", frm_q[frm_q.size()-1], 48'h104104104104);
    check("per_v10", per_q[per_q.size()-1], 32'h10101010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/red_pitaya_pwm_rx.md
RED_PITAYA_PWM_RX -- requirements
Module: red_pitaya_pwm_rx

Interface
REQ-001 SHALL have parameter PWM_FULL, default 156, PWM period length in clocks (100% value).
REQ-002 SHALL have parameter SYNC_DLY, default 3, clocks from sync_i sample to first frame sample on pwm_i; legal range 0..PWM_FULL-2.
REQ-003 SHALL have port clk_i  input  1  PWM clock (2x DAC clock domain); all logic on rising edge.
REQ-004 SHALL have port rstn_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ena_i  input  1  decoder enable.
REQ-006 SHALL have port pwm_i  input  4  PWM lines CHA..CHD, bit n = channel n, synchronous to clk_i.
REQ-007 SHALL have port sync_i  input  1  one-cycle frame sync pulse from the PWM generator.
REQ-008 SHALL have port per_cnt_o  output  32  per-period high count, 8 bits per channel, channel n at [8n+7:8n].
REQ-009 SHALL have port per_vld_o  output  1  one-cycle strobe, per_cnt_o updated.
REQ-010 SHALL have port frm_sum_o  output  48  16-period high-count sum, 12 bits per channel, channel n at [12n+11:12n].
REQ-011 SHALL have port frm_vld_o  output  1  one-cycle strobe, frm_sum_o updated.
REQ-012 SHALL have port locked_o  output  1  high while the decoder is frame-aligned.
REQ-013 SHALL have port sync_err_o  output  1  one-cycle strobe, sync_i arrived at an inconsistent phase.

Function
REQ-014 SHALL implement FSM IDLE, ALIGN, LOCK; locked_o = (state==LOCK).
REQ-015 IDLE: on sync_i=1 with ena_i=1 at cycle t -> ALIGN; delay counter loaded so that cycle t+1+SYNC_DLY is period position 1, frame period 0.
REQ-016 ALIGN: on reaching position 1 -> LOCK; counters pcnt=1, fcnt=0; accumulators cleared.
REQ-017 LOCK: pcnt counts 1..PWM_FULL then wraps to 1; fcnt increments at wrap, 15 wraps to 0.
REQ-018 LOCK: sync_i at fcnt==15 and pcnt==PWM_FULL-SYNC_DLY is consistent, no action.
REQ-019 LOCK: any other sync_i -> sync_err_o pulse next cycle, state ALIGN re-armed from that sync, partial period/frame discarded with no strobes.
REQ-020 ena_i=0 in any state -> IDLE next cycle, counters/accumulators cleared, outputs hold last values.
REQ-021 In LOCK, per-channel 8-bit high counter counts cycles with pwm_i[n]=1 across positions 1..PWM_FULL.
REQ-022 At pcnt==PWM_FULL: per_cnt_o <= count including that cycle's sample; per_vld_o pulses the following cycle; counters restart at 0.
REQ-023 Per-channel 12-bit frame sum adds each completed period count; at fcnt==15 period end frm_sum_o <= total, frm_vld_o pulses together with that period's per_vld_o.
REQ-024 Widths sufficient without saturation: max 156 per period, 2496 per frame; frm_sum_o equals 16*v + popcount(dither) for an encoder value v (v<=PWM_FULL-1).
REQ-025 sync_i in ALIGN re-arms the delay from the newest pulse, no error.

Reset
REQ-026 rstn_i=0 SHALL asynchronously force IDLE, all counters 0, per_cnt_o=0, frm_sum_o=0, all strobes 0, locked_o=0.
REQ-027 Release SHALL take effect on the next clk_i edge; no frame data before first valid sync.

Structure
REQ-028 PWM_FULL default, counter widths and FSM state encoding SHALL live in shared package red_pitaya_pwm_pkg, reused by the generator.
REQ-029 One sub-module red_pitaya_pwm_rx_ch (single-channel high counter + frame accumulator) SHALL be instantiated 4 times.

Verification
REQ-030 Encoder loopback, value 0x50_0000 all channels -> per_cnt_o bytes 0x50 every 156 clk, frm_sum_o fields 1280.
REQ-031 Value 0x32_00FF on CHB -> per_cnt 0x33 for 8 periods then 0x32 for 8, frm_sum 808; other channels unaffected.
REQ-032 pwm_i held 1 -> per_cnt 156, frm_sum 2496; held 0 -> 0, 0; no overflow.
REQ-033 Sync shifted by 5 clk while locked -> sync_err_o one pulse, locked_o low, relock after SYNC_DLY+1 clk, next frm_vld one full frame later.
REQ-034 rstn_i asserted mid-frame and ena_i dropped mid-frame -> outputs per REQ-026/020, no strobes until next sync plus a full period.
